adc_sample_writer: RTL and testbench

Capture stage between the ADC serial front end and the dual-port BRAM. Takes each 12-bit conversion result (`dataAdc` with `readyAdc` strobe) from the Wac controller. Writes it as two bytes into BRAM port B at consecutive addresses until `nSamples` results are stored, then flags completion so the PC can read the buffer back over EPP. Runs entirely on the system clock and owns BRAM port B while armed.

---
 rtl/adc_sample_writer.sv | 120 ++++++++++++
 tb/tb_adc_sample_writer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/adc_sample_writer.sv
// Capture stage: stores each 12-bit ADC result as two bytes in BRAM port B
// until the requested number of samples is written, then flags completion.
module adc_sample_writer #(
    parameter logic [11:0] BASE_ADDR   = 12'h010,
    parameter int unsigned MAX_SAMPLES = 2040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] nSamples,
    input  logic [11:0] dataAdc,
    input  logic        readyAdc,
    output logic [11:0] busBramAddr,
    output logic [7:0]  busBramOut,
    output logic        ctrlWeBram,
    output logic        clkBram,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic [11:0] sampleCnt
);

    localparam int unsigned AW = 12;
    localparam int unsigned CW = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t        state;
    logic          rdyQ;
    logic [AW-1:0] ptr;
    logic [CW-1:0] nLatched;
    logic [3:0]    sampleHi;

    logic          rdyEdge;
    logic [CW-1:0] nClamped;
    logic [CW-1:0] cntNext;

    assign clkBram  = clk;
    assign rdyEdge  = readyAdc & ~rdyQ;
    assign nClamped = (nSamples > CW'(MAX_SAMPLES)) ? CW'(MAX_SAMPLES) : nSamples;
    assign cntNext  = sampleCnt + CW'(1);

    // Outputs are set on the edge that enters each state, so the low byte is
    // on the bus during WR_LO and the high byte during WR_HI.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rdyQ        <= 1'b0;
            ptr         <= '0;
            nLatched    <= '0;
            sampleHi    <= '0;
            busBramAddr <= '0;
            busBramOut  <= '0;
            ctrlWeBram  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            sampleCnt   <= '0;
        end else begin
            rdyQ       <= readyAdc;
            ctrlWeBram <= 1'b0;
            busBramOut <= '0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        nLatched  <= nClamped;
                        sampleCnt <= '0;
                        overrun   <= 1'b0;
                        ptr       <= BASE_ADDR;
                        if (nClamped == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                S_WAIT: begin
                    if (rdyEdge) begin
                        sampleHi    <= dataAdc[11:8];
                        ctrlWeBram  <= 1'b1;
                        busBramAddr <= ptr;
                        busBramOut  <= dataAdc[7:0];
                        ptr         <= ptr + AW'(1);
                        state       <= S_WR_LO;
                    end
                end
                S_WR_LO: begin
                    if (rdyEdge) overrun <= 1'b1;
                    ctrlWeBram  <= 1'b1;
                    busBramAddr <= ptr;
                    busBramOut  <= {4'b0000, sampleHi};
                    ptr         <= ptr + AW'(1);
                    state       <= S_WR_HI;
                end
                S_WR_HI: begin
                    if (rdyEdge) overrun <= 1'b1;
                    sampleCnt <= cntNext;
                    if (cntNext == nLatched) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_writer.sv
// Directed bench for adc_sample_writer: per-cycle vector table plus
// hand-written sequences for level hold, reset abort and the capacity clamp.
module tb_adc_sample_writer;

    logic        clk = 1'b0;
    logic        rst, start, readyAdc;
    logic [11:0] nSamples, dataAdc;
    logic [11:0] busBramAddr, sampleCnt;
    logic [7:0]  busBramOut;
    logic        ctrlWeBram, clkBram, busy, done, overrun;

    adc_sample_writer dut (
        .clk(clk), .rst(rst), .start(start), .nSamples(nSamples),
        .dataAdc(dataAdc), .readyAdc(readyAdc), .busBramAddr(busBramAddr),
        .busBramOut(busBramOut), .ctrlWeBram(ctrlWeBram), .clkBram(clkBram),
        .busy(busy), .done(done), .overrun(overrun), .sampleCnt(sampleCnt)
    );

    always #5 clk = ~clk;

    // BRAM port B model
    logic [7:0]  mem [4096];
    int          wrCount   = 0;
    logic [11:0] lastWrAddr = '0;
    logic        wrapSeen  = 1'b0;
    always @(posedge clkBram) begin
        if (ctrlWeBram === 1'b1) begin
            mem[busBramAddr] <= busBramOut;
            wrCount          <= wrCount + 1;
            lastWrAddr       <= busBramAddr;
            if (busBramAddr < 12'h010) wrapSeen <= 1'b1;
        end
    end

    typedef struct {
        logic        rst;
        logic        start;
        logic [11:0] n;
        logic        rdy;
        logic [11:0] data;
        logic        chkMem;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  dout;
        logic        busy;
        logic        done;
        logic        ovr;
        logic [11:0] cnt;
    } vec_t;

    vec_t vecs [23];
    int   nVec = 0;
    int   nErr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [11:0] n,
                       input logic rd, input logic [11:0] d);
        @(negedge clk);
        rst = r; start = s; nSamples = n; readyAdc = rd; dataAdc = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] outs();
        return {ctrlWeBram, busBramAddr, busBramOut, busy, done, overrun, sampleCnt};
    endfunction

    int w0;

    initial begin
        rst = 1'b1; start = 1'b0; nSamples = '0; readyAdc = 1'b0; dataAdc = '0;

        //           rst start n      rdy data   chk we addr    dout  bsy dn ov cnt
        vecs[0]  = '{1, 0, 12'd0, 0, 12'h000, 0, 0, 12'h000, 8'h00, 0, 0, 0, 12'd0};
        vecs[1]  = '{0, 1, 12'd3, 0, 12'h000, 0, 0, 12'h000, 8'h00, 1, 0, 0, 12'd0};
        vecs[2]  = '{0, 0, 12'd0, 0, 12'h000, 0, 0, 12'h000, 8'h00, 1, 0, 0, 12'd0};
        vecs[3]  = '{0, 0, 12'd0, 1, 12'hABC, 0, 1, 12'h010, 8'hBC, 1, 0, 0, 12'd0};
        vecs[4]  = '{0, 0, 12'd0, 1, 12'hABC, 0, 1, 12'h011, 8'h0A, 1, 0, 0, 12'd0};
        vecs[5]  = '{0, 0, 12'd0, 0, 12'h000, 0, 0, 12'h011, 8'h00, 1, 0, 0, 12'd1};
        vecs[6]  = '{0, 0, 12'd0, 0, 12'h000, 0, 0, 12'h011, 8'h00, 1, 0, 0, 12'd1};
        vecs[7]  = '{0, 0, 12'd0, 1, 12'h123, 0, 1, 12'h012, 8'h23, 1, 0, 0, 12'd1};
        vecs[8]  = '{0, 0, 12'd0, 0, 12'h000, 0, 1, 12'h013, 8'h01, 1, 0, 0, 12'd1};
        vecs[9]  = '{0, 0, 12'd0, 0, 12'h000, 0, 0, 12'h013, 8'h00, 1, 0, 0, 12'd2};
        vecs[10] = '{0, 0, 12'd0, 1, 12'hFFF, 0, 1, 12'h014, 8'hFF, 1, 0, 0, 12'd2};
        vecs[11] = '{0, 0, 12'd0, 1, 12'hFFF, 0, 1, 12'h015, 8'h0F, 1, 0, 0, 12'd2};
        vecs[12] = '{0, 0, 12'd0, 0, 12'h000, 0, 0, 12'h015, 8'h00, 0, 1, 0, 12'd3};
        // zero-length start from DONE
        vecs[13] = '{0, 1, 12'd0, 0, 12'h000, 1, 0, 12'h015, 8'h00, 0, 1, 0, 12'd0};
        vecs[14] = '{0, 0, 12'd0, 0, 12'h000, 0, 0, 12'h015, 8'h00, 0, 1, 0, 12'd0};
        // overrun: second edge two clocks after the first
        vecs[15] = '{0, 1, 12'd2, 0, 12'h000, 0, 0, 12'h015, 8'h00, 1, 0, 0, 12'd0};
        vecs[16] = '{0, 0, 12'd0, 1, 12'h456, 0, 1, 12'h010, 8'h56, 1, 0, 0, 12'd0};
        vecs[17] = '{0, 0, 12'd0, 0, 12'h000, 0, 1, 12'h011, 8'h04, 1, 0, 0, 12'd0};
        vecs[18] = '{0, 0, 12'd0, 1, 12'h789, 0, 0, 12'h011, 8'h00, 1, 0, 1, 12'd1};
        vecs[19] = '{0, 0, 12'd0, 0, 12'h000, 0, 0, 12'h011, 8'h00, 1, 0, 1, 12'd1};
        vecs[20] = '{0, 0, 12'd0, 1, 12'h321, 0, 1, 12'h012, 8'h21, 1, 0, 1, 12'd1};
        vecs[21] = '{0, 0, 12'd0, 0, 12'h000, 0, 1, 12'h013, 8'h03, 1, 0, 1, 12'd1};
        vecs[22] = '{0, 0, 12'd0, 0, 12'h000, 0, 0, 12'h013, 8'h00, 0, 1, 1, 12'd2};

        for (int i = 0; i < 23; i++) begin
            cyc(vecs[i].rst, vecs[i].start, vecs[i].n, vecs[i].rdy, vecs[i].data);
            check($sformatf("vec%0d", i), 64'(outs()),
                  64'({vecs[i].we, vecs[i].addr, vecs[i].dout, vecs[i].busy,
                       vecs[i].done, vecs[i].ovr, vecs[i].cnt}));
            if (vecs[i].chkMem) begin
                check("basic_bram", 64'({mem[12'h010], mem[12'h011], mem[12'h012],
                                          mem[12'h013], mem[12'h014], mem[12'h015]}),
                      64'(48'hBC0A_2301_FF0F));
                check("zero_len_nowrite", 64'(wrCount), 64'd6);
            end
        end

        // Level hold for 20 clocks with an ignored start in the middle
        cyc(0, 1, 12'd2, 0, 12'h000);
        w0 = wrCount;
        for (int i = 0; i < 20; i++) cyc(0, (i == 5), 12'd1, 1, 12'h9C3);
        check("hold_writes", 64'(wrCount - w0), 64'd2);
        check("hold_state", 64'({busy, done, sampleCnt}), 64'({1'b1, 1'b0, 12'd1}));
        cyc(0, 0, 12'd0, 0, 12'h000);
        cyc(0, 0, 12'd0, 1, 12'h111);
        for (int i = 0; i < 3; i++) cyc(0, 0, 12'd0, 0, 12'h000);
        check("hold_end", 64'({busy, done, sampleCnt, busBramAddr}),
              64'({1'b0, 1'b1, 12'd2, 12'h013}));
        check("hold_bram", 64'({mem[12'h010], mem[12'h011], mem[12'h012], mem[12'h013]}),
              64'(32'hC309_1101));

        // Reset between the low and high byte writes
        cyc(0, 1, 12'd2, 0, 12'h000);
        cyc(0, 0, 12'd0, 1, 12'hEEE);
        check("rst_lo_write", 64'({ctrlWeBram, busBramAddr, busBramOut}),
              64'({1'b1, 12'h010, 8'hEE}));
        cyc(1, 0, 12'd0, 0, 12'h000);
        check("rst_outputs", 64'(outs()), 64'd0);
        w0 = wrCount;
        for (int i = 0; i < 3; i++) cyc(0, 0, 12'd0, 0, 12'h000);
        check("rst_no_writes", 64'(wrCount - w0), 64'd0);
        cyc(0, 1, 12'd1, 0, 12'h000);
        cyc(0, 0, 12'd0, 1, 12'h5A5);
        for (int i = 0; i < 2; i++) cyc(0, 0, 12'd0, 0, 12'h000);
        check("rst_restart_done", 64'({busy, done, sampleCnt, busBramAddr}),
              64'({1'b0, 1'b1, 12'd1, 12'h011}));
        check("rst_restart_bram", 64'({mem[12'h010], mem[12'h011]}), 64'(16'hA505));

        // Clamp: nSamples=4095 stores 2040 samples, last byte at 0xFFF
        cyc(0, 1, 12'hFFF, 0, 12'h000);
        w0 = wrCount;
        for (int i = 0; i < 2040; i++) begin
            cyc(0, 0, 12'd0, 1, 12'(i));
            for (int k = 0; k < 3; k++) cyc(0, 0, 12'd0, 0, 12'h000);
        end
        check("clamp_done", 64'({busy, done, overrun, sampleCnt}),
              64'({1'b0, 1'b1, 1'b0, 12'd2040}));
        check("clamp_writes", 64'(wrCount - w0), 64'd4080);
        check("clamp_last_addr", 64'(lastWrAddr), 64'h0FFF);
        check("clamp_last_bytes", 64'({mem[12'hFFE], mem[12'hFFF]}), 64'(16'hF707));
        check("clamp_no_wrap", 64'(wrapSeen), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
